// File: rtl/rgb_cmd_pkg.sv
// Shared constants, receiver state encoding and command decode for the RGB UART command path.
package rgb_cmd_pkg;

  localparam int PWM_STEPS = 9;

  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;
  localparam logic [2:0] COLOR_OFF     = 3'b000;

  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_B = 8'h42;
  localparam logic [7:0] ASCII_Y = 8'h59;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_M = 8'h4D;
  localparam logic [7:0] ASCII_W = 8'h57;
  localparam logic [7:0] ASCII_K = 8'h4B;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Returns {hit, color}; lower-case letters fold onto upper case.
  function automatic logic [3:0] decode_color(input logic [7:0] b);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
    case (u)
      ASCII_R: return {1'b1, COLOR_RED};
      ASCII_G: return {1'b1, COLOR_GREEN};
      ASCII_B: return {1'b1, COLOR_BLUE};
      ASCII_Y: return {1'b1, COLOR_YELLOW};
      ASCII_C: return {1'b1, COLOR_CYAN};
      ASCII_M: return {1'b1, COLOR_MAGENTA};
      ASCII_W: return {1'b1, COLOR_WHITE};
      ASCII_K: return {1'b1, COLOR_OFF};
      default: return {1'b0, COLOR_OFF};
    endcase
  endfunction

endpackage

// File: rtl/rgb_cmd_rx_uart_rx_8n1.sv
// 8N1 serial receiver: 2-flop synchroniser, down-counting bit timer, byte FSM.
//   state        | meaning
//   ST_IDLE      | line idle, waiting for a synchronised low
//   ST_START     | half-bit wait, then confirm start bit
//   ST_DATA      | sampling 8 data bits, LSB first
//   ST_STOP      | sampling stop bit
//   ST_WAIT_IDLE | framing error seen, waiting for line high
module uart_rx_8n1
  import rgb_cmd_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       byte_strobe,
  output logic [7:0] byte_data
);

  localparam int TW = (DIV > 2) ? $clog2(DIV) : 1;

  logic      rx_s1, rx_s2;
  rx_state_t state;
  logic [TW-1:0] timer;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  // Lets the decoder update on the same edge that raises rx_valid.
  assign byte_strobe = (state == ST_STOP) && (timer == '0) && rx_s2;
  assign byte_data   = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      state     <= ST_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s2) begin
            state <= ST_START;
            timer <= TW'(DIV / 2 - 1);
          end
        end
        ST_START: begin
          if (timer != '0) timer <= timer - TW'(1);
          else if (!rx_s2) begin
            state   <= ST_DATA;
            timer   <= TW'(DIV - 1);
            bit_cnt <= '0;
          end else state <= ST_IDLE;
        end
        ST_DATA: begin
          if (timer != '0) timer <= timer - TW'(1);
          else begin
            shreg <= {rx_s2, shreg[7:1]};
            timer <= TW'(DIV - 1);
            if (bit_cnt == 3'd7) state <= ST_STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_STOP: begin
          if (timer != '0) timer <= timer - TW'(1);
          else if (rx_s2) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: if (rx_s2) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rgb_cmd_rx.sv
// UART colour/brightness command decoder driving the SB_RGBA_DRV PWM inputs.
// Brightness PWM is built only when RGB_CMD_RX_PWM_EN is defined.
module rgb_cmd_rx
  import rgb_cmd_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       red_on,
  output logic       green_on,
  output logic       blue_on,
  output logic [2:0] color,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int DIV = CLK_HZ / BAUD;

  logic       byte_strobe;
  logic [7:0] byte_data;
  logic [3:0] dec;

  uart_rx_8n1 #(.DIV(DIV)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .byte_strobe (byte_strobe),
    .byte_data   (byte_data)
  );

  assign dec = decode_color(byte_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) color <= COLOR_OFF;
    else if (byte_strobe && dec[3]) color <= dec[2:0];
  end

`ifdef RGB_CMD_RX_PWM_EN
  logic [3:0] level;
  logic [3:0] pwm_cnt;
  logic       pwm_gate;

  assign pwm_gate = (pwm_cnt < level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level    <= 4'(PWM_STEPS);
      pwm_cnt  <= '0;
      red_on   <= 1'b0;
      green_on <= 1'b0;
      blue_on  <= 1'b0;
    end else begin
      pwm_cnt  <= (pwm_cnt == 4'(PWM_STEPS - 1)) ? 4'd0 : pwm_cnt + 4'd1;
      if (byte_strobe && byte_data >= ASCII_0 && byte_data <= ASCII_9)
        level <= 4'(byte_data - ASCII_0);
      red_on   <= color[2] & pwm_gate;
      green_on <= color[1] & pwm_gate;
      blue_on  <= color[0] & pwm_gate;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_on   <= 1'b0;
      green_on <= 1'b0;
      blue_on  <= 1'b0;
    end else begin
      red_on   <= color[2];
      green_on <= color[1];
      blue_on  <= color[0];
    end
  end
`endif

endmodule
